iiitb_piso_tx: RTL

Parallel-in serial-out frame transmitter: the serialising end of the 4-bit parallel register datapath. It accepts a parallel word through a valid/ready handshake and shifts it onto a single serial line as a framed bit stream: start bit, data MSB-first, even parity, stop bit. It sits between the parallel register stage and the off-block serial link, and a matching receiver sits at the far end of the link.

---
 rtl/iiitb_piso_tx_if.sv | 23 ++
 rtl/iiitb_piso_tx.sv | 115 +++++++++++
 2 files changed

// File: rtl/iiitb_piso_tx_if.sv
// Handshake and serial-line bundle between the parallel register stage and the
// frame transmitter.
`timescale 1ns/1ps
interface iiitb_piso_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] pi;
    logic             load_valid;
    logic             load_ready;
    logic             so;
    logic             busy;
    logic             done;

    modport master (
        output pi, load_valid,
        input  load_ready, so, busy, done
    );

    modport slave (
        input  pi, load_valid,
        output load_ready, so, busy, done
    );
endinterface

// File: rtl/iiitb_piso_tx.sv
// Parallel-in serial-out frame transmitter: start bit, data MSB first,
// even parity, stop bit, each bit held for DIV clock cycles.
//
// state  | meaning
// IDLE   | line high, ready for a new word
// START  | start bit (0)
// DATA   | data bits, MSB first
// PARITY | even parity of the latched word
// STOP   | stop bit (1); leaving it raises done for one cycle
`timescale 1ns/1ps
module iiitb_piso_tx #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic               clk,
    input  logic               clear,
    iiitb_piso_tx_if.slave     bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    bit_q;
    logic [WIDTH-1:0] shreg_q;
    logic             par_q;
    logic             so_q;
    logic             busy_q;
    logic             done_q;
    logic             cnt_last;

    assign cnt_last = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            so_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load_valid) begin
                        shreg_q <= bus.pi;
                        par_q   <= ^bus.pi;
                        state_q <= START;
                        so_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end
                end
                default: begin
                    if (!cnt_last) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                        // The next bit level is registered on the same edge the bit period ends.
                        case (state_q)
                            START: begin
                                state_q <= DATA;
                                so_q    <= shreg_q[WIDTH-1];
                                shreg_q <= shreg_q << 1;
                                bit_q   <= '0;
                            end
                            DATA: begin
                                if (bit_q == BW'(WIDTH - 1)) begin
                                    state_q <= PARITY;
                                    so_q    <= par_q;
                                end else begin
                                    bit_q   <= bit_q + BW'(1);
                                    so_q    <= shreg_q[WIDTH-1];
                                    shreg_q <= shreg_q << 1;
                                end
                            end
                            PARITY: begin
                                state_q <= STOP;
                                so_q    <= 1'b1;
                            end
                            STOP: begin
                                state_q <= IDLE;
                                so_q    <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                            default: begin
                                state_q <= IDLE;
                                so_q    <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.so         = so_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule
